ddr3_avl_arbiter: RTL

Shares the single DDR3 Avalon-MM port between two requesters.
- Port 0: VGA line-fetch reader, high priority.
- Port 1: CSR/host read-write path.
Sits between the VGA fetch/CSR logic and the DDR3 controller inside the top level. Sequences read commands and multi-beat write bursts, and routes returning read data to the issuing port in order through a tag FIFO.

---
 rtl/ddr3_avl_arbiter_if.sv | 39 +++
 rtl/ddr3_avl_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_avl_arbiter_if.sv
// Avalon-MM command/data bundle between the DDR3 arbiter (master) and the DDR3 controller (slave).
interface ddr3_avl_arbiter_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 128
);
    logic              ready;
    logic              burstbegin;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic              read_req;
    logic              write_req;
    logic [DATA_W-1:0] wr_data;
    logic              read_data_valid;
    logic [DATA_W-1:0] read_data;

    modport master (
        input  ready,
        output burstbegin,
        output addr,
        output size,
        output read_req,
        output write_req,
        output wr_data,
        input  read_data_valid,
        input  read_data
    );

    modport slave (
        output ready,
        input  burstbegin,
        input  addr,
        input  size,
        input  read_req,
        input  write_req,
        input  wr_data,
        output read_data_valid,
        output read_data
    );
endinterface

// File: rtl/ddr3_avl_arbiter.sv
// Two-port DDR3 Avalon arbiter: port 0 (VGA reads, high priority) and port 1 (CSR read/write).
// Optional macro DDR3_ARB_FAIRNESS_EN forces a port-1 grant after MAX_WAIT back-to-back port-0 grants.
module ddr3_avl_arbiter #(
    parameter int ADDR_W             = 26,
    parameter int DATA_W             = 128,
    parameter int MAX_RD_OUTSTANDING = 8,
    parameter int MAX_WAIT           = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_read_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [2:0]        p0_size,
    output logic              p0_ack,
    output logic              p0_rdata_valid,

    input  logic              p1_read_req,
    input  logic              p1_write_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [2:0]        p1_size,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_wr_beat_ack,
    output logic              p1_ack,
    output logic              p1_rdata_valid,

    output logic [DATA_W-1:0] rdata,
    output logic              err_unexpected_rdata,

    ddr3_avl_arbiter_if.master avl
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_CMD   = 2'd1;
    localparam logic [1:0] WR_BURST = 2'd2;

    localparam int PTR_W = $clog2(MAX_RD_OUTSTANDING) + 1;
    localparam int IDX_W = PTR_W - 1;

    if (MAX_RD_OUTSTANDING < 2 || (MAX_RD_OUTSTANDING & (MAX_RD_OUTSTANDING - 1)) != 0
        || MAX_WAIT < 1) begin : g_param_check
        $error("ddr3_avl_arbiter: MAX_RD_OUTSTANDING must be a power of 2 >= 2 and MAX_WAIT >= 1");
    end

    // A zero-length request still moves one beat.
    function automatic logic [2:0] eff_size(input logic [2:0] s);
        return (s == 3'd0) ? 3'd1 : s;
    endfunction

    logic [1:0]        state;
    logic [ADDR_W-1:0] cmd_addr;
    logic [2:0]        cmd_size;
    logic              cmd_port;
    logic [2:0]        beats_left;
    logic              first_beat;

    logic [3:0]        tag_mem [MAX_RD_OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [2:0]        head_seen;
    logic              fifo_empty;
    logic              fifo_full;
    logic              head_port;
    logic [2:0]        head_size;

    logic              p0_ok;
    logic              p1_rd_ok;
    logic              p1_wr_ok;
    logic              p1_ok;
    logic              force_p1;
    logic              grant_p0;
    logic              grant_p1_rd;
    logic              grant_p1_wr;

    logic              rd_accept;
    logic              wr_accept;
    logic              wr_last;
    logic              push;
    logic              pop;
    logic              beat_ok;

    // Full when the index bits match but the wrap bits differ.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1])
                     && (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign head_port  = tag_mem[rd_ptr[IDX_W-1:0]][3];
    assign head_size  = tag_mem[rd_ptr[IDX_W-1:0]][2:0];

    // A port-1 read that is blocked on a full FIFO keeps the write behind it waiting too.
    assign p0_ok    = p0_read_req && !fifo_full;
    assign p1_rd_ok = p1_read_req && !fifo_full;
    assign p1_wr_ok = p1_write_req && !p1_read_req;
    assign p1_ok    = p1_rd_ok || p1_wr_ok;

`ifdef DDR3_ARB_FAIRNESS_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              p1_req;

    assign p1_req   = p1_read_req || p1_write_req;
    assign force_p1 = (wait_cnt == WAIT_W'(MAX_WAIT)) && p1_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!p1_req || grant_p1_rd || grant_p1_wr) begin
            wait_cnt <= '0;
        end else if (grant_p0 && wait_cnt != WAIT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign force_p1 = 1'b0;
`endif

    always_comb begin
        grant_p0    = 1'b0;
        grant_p1_rd = 1'b0;
        grant_p1_wr = 1'b0;
        if (state == IDLE) begin
            if (p0_ok && !force_p1) begin
                grant_p0 = 1'b1;
            end else if (p1_rd_ok) begin
                grant_p1_rd = 1'b1;
            end else if (p1_wr_ok) begin
                grant_p1_wr = 1'b1;
            end
        end
    end

    assign rd_accept      = (state == RD_CMD) && avl.ready;
    assign wr_accept      = (state == WR_BURST) && avl.ready;
    assign wr_last        = wr_accept && (beats_left == 3'd1);

    assign p0_ack         = rd_accept && !cmd_port;
    assign p1_ack         = (rd_accept && cmd_port) || wr_last;
    assign p1_wr_beat_ack = wr_accept;

    assign avl.read_req   = (state == RD_CMD);
    assign avl.write_req  = (state == WR_BURST);
    assign avl.burstbegin = (state == RD_CMD) || ((state == WR_BURST) && first_beat);
    assign avl.addr       = cmd_addr;
    assign avl.size       = cmd_size;
    assign avl.wr_data    = (state == WR_BURST) ? p1_wdata : '0;

    // Command sequencer: IDLE arbitrates, RD_CMD/WR_BURST hold until the controller takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cmd_addr   <= '0;
            cmd_size   <= '0;
            cmd_port   <= 1'b0;
            beats_left <= '0;
            first_beat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_p0) begin
                        cmd_addr <= p0_addr;
                        cmd_size <= eff_size(p0_size);
                        cmd_port <= 1'b0;
                        state    <= RD_CMD;
                    end else if (grant_p1_rd) begin
                        cmd_addr <= p1_addr;
                        cmd_size <= eff_size(p1_size);
                        cmd_port <= 1'b1;
                        state    <= RD_CMD;
                    end else if (grant_p1_wr) begin
                        cmd_addr   <= p1_addr;
                        cmd_size   <= eff_size(p1_size);
                        cmd_port   <= 1'b1;
                        beats_left <= eff_size(p1_size);
                        first_beat <= 1'b1;
                        state      <= WR_BURST;
                    end
                end
                RD_CMD: begin
                    if (avl.ready) begin
                        state <= IDLE;
                    end
                end
                WR_BURST: begin
                    if (avl.ready) begin
                        first_beat <= 1'b0;
                        beats_left <= beats_left - 3'd1;
                        if (beats_left == 3'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read return: beats go to the head tag; the tag retires on its last beat.
    assign push           = rd_accept;
    assign beat_ok        = avl.read_data_valid && !fifo_empty;
    assign pop            = beat_ok && (3'(head_seen + 3'd1) == head_size);
    assign p0_rdata_valid = beat_ok && !head_port;
    assign p1_rdata_valid = beat_ok && head_port;
    assign rdata          = avl.read_data;

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr[IDX_W-1:0]] <= {cmd_port, cmd_size};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            head_seen            <= '0;
            err_unexpected_rdata <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                head_seen <= '0;
            end else if (beat_ok) begin
                head_seen <= head_seen + 3'd1;
            end
            if (avl.read_data_valid && fifo_empty) begin
                err_unexpected_rdata <= 1'b1;
            end
        end
    end

endmodule
